// File: rtl/lfsr_checker.sv
// Purpose : self-synchronising checker for an XNOR Fibonacci LFSR bit stream
//           (taps BITS, BITS-1). It seeds from the stream, verifies, locks,
//           then flywheels its own copy and counts mismatches.
// Latency : all outputs are registered and reflect the bit consumed on the
//           previous rising edge. Lock is reached after BITS+LOCK_GOOD clean
//           valid bits.
// Backpressure: none. A bit is consumed on every cycle with in_valid=1.
//           Gaps hold all state; pulses drop and clr_count still applies.
// Ports   : clk/reset (async, active-high); in_valid/in_bit carry the stream;
//           clr_count clears err_count. The outputs are locked, err_pulse,
//           sync_lost and err_count.
module lfsr_checker #(
    parameter int BITS      = 3,
    parameter int LOCK_GOOD = 8,
    parameter int LOSS_ERRS = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr_count,
    output logic             locked,
    output logic             err_pulse,
    output logic             sync_lost,
    output logic [CNT_W-1:0] err_count
);

    localparam int SEED_W = $clog2(BITS + 1);
    localparam int GOOD_W = $clog2(LOCK_GOOD + 1);
    localparam int BAD_W  = $clog2(LOSS_ERRS + 1);

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [BITS-1:0]    r_s, w_s_nxt;
    logic [SEED_W-1:0]  r_seed_cnt, w_seed_cnt_nxt;
    logic [GOOD_W-1:0]  r_good_cnt, w_good_cnt_nxt;
    logic [BAD_W-1:0]   r_bad_cnt, w_bad_cnt_nxt;
    logic [CNT_W-1:0]   r_err_count, w_err_count_nxt;
    logic               r_err_pulse, w_err_pulse_nxt;
    logic               r_sync_lost, w_sync_lost_nxt;

    logic               w_pred;
    logic               w_all_ones;

    // Next bit the generator would emit from the current local register.
    assign w_pred     = ~(r_s[BITS-1] ^ r_s[BITS-2]);
    // The XNOR lock-up state. It predicts itself forever, so it is never trusted.
    assign w_all_ones = &r_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_SEED;
            r_s         <= '0;
            r_seed_cnt  <= '0;
            r_good_cnt  <= '0;
            r_bad_cnt   <= '0;
            r_err_count <= '0;
            r_err_pulse <= 1'b0;
            r_sync_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_s         <= w_s_nxt;
            r_seed_cnt  <= w_seed_cnt_nxt;
            r_good_cnt  <= w_good_cnt_nxt;
            r_bad_cnt   <= w_bad_cnt_nxt;
            r_err_count <= w_err_count_nxt;
            r_err_pulse <= w_err_pulse_nxt;
            r_sync_lost <= w_sync_lost_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_s_nxt         = r_s;
        w_seed_cnt_nxt  = r_seed_cnt;
        w_good_cnt_nxt  = r_good_cnt;
        w_bad_cnt_nxt   = r_bad_cnt;
        w_err_count_nxt = r_err_count;
        w_err_pulse_nxt = 1'b0;
        w_sync_lost_nxt = 1'b0;

        if (in_valid) begin
            case (r_state)
                ST_SEED: begin
                    w_s_nxt        = {r_s[BITS-2:0], in_bit};
                    w_seed_cnt_nxt = r_seed_cnt + SEED_W'(1);
                    if (r_seed_cnt == SEED_W'(BITS - 1)) begin
                        w_state_nxt    = ST_VERIFY;
                        w_good_cnt_nxt = '0;
                    end
                end
                ST_VERIFY: begin
                    w_s_nxt = {r_s[BITS-2:0], in_bit};
                    if ((in_bit == w_pred) && !w_all_ones) begin
                        w_good_cnt_nxt = r_good_cnt + GOOD_W'(1);
                        if (r_good_cnt == GOOD_W'(LOCK_GOOD - 1)) begin
                            w_state_nxt   = ST_LOCKED;
                            w_bad_cnt_nxt = '0;
                        end
                    end else begin
                        w_good_cnt_nxt = '0;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: the received bit never enters the register.
                    w_s_nxt = {r_s[BITS-2:0], w_pred};
                    if (in_bit == w_pred) begin
                        w_bad_cnt_nxt = '0;
                    end else begin
                        w_err_pulse_nxt = 1'b1;
                        if (r_err_count != {CNT_W{1'b1}}) begin
                            w_err_count_nxt = r_err_count + CNT_W'(1);
                        end
                        w_bad_cnt_nxt = r_bad_cnt + BAD_W'(1);
                        if (r_bad_cnt == BAD_W'(LOSS_ERRS - 1)) begin
                            w_sync_lost_nxt = 1'b1;
                            w_state_nxt     = ST_SEED;
                            w_seed_cnt_nxt  = '0;
                            w_s_nxt         = '0;
                        end
                    end
                end
                default: begin
                    w_state_nxt    = ST_SEED;
                    w_s_nxt        = '0;
                    w_seed_cnt_nxt = '0;
                end
            endcase
        end

        // The clear wins over an increment in the same cycle.
        if (clr_count) begin
            w_err_count_nxt = '0;
        end
    end

    assign locked    = (r_state == ST_LOCKED);
    assign err_pulse = r_err_pulse;
    assign sync_lost = r_sync_lost;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_lfsr_checker.sv
// Purpose : directed self-checking bench for lfsr_checker using the default
//           parameters and the period-7 stream 1,1,0,1,0,0,0.
// Latency : inputs are driven on the falling edge and outputs are sampled 1ns
//           after the rising edge that consumes them.
// Backpressure: not applicable. The bench drives in_valid directly.
module tb_lfsr_checker;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_bit;
    logic        clr_count;
    logic        locked;
    logic        err_pulse;
    logic        sync_lost;
    logic [15:0] err_count;

    int          n_cmp;
    int          n_fail;
    int          idx;
    logic [6:0]  pat;
    logic [15:0] exp_cnt;

    lfsr_checker #(
        .BITS(3), .LOCK_GOOD(8), .LOSS_ERRS(4), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .clr_count(clr_count), .locked(locked), .err_pulse(err_pulse),
        .sync_lost(sync_lost), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle. A valid bit is the next stream bit, optionally inverted.
    // An invalid cycle carries a garbage bit, which must be ignored.
    task automatic send(input logic v, input logic inv, input logic clr);
        @(negedge clk);
        in_valid  = v;
        in_bit    = v ? (pat[idx % 7] ^ inv) : 1'($urandom);
        clr_count = clr;
        if (v) idx++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; clr_count = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clr_count = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({locked, err_pulse, sync_lost} !== 3'b000 || err_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_values: locked=%0b pulse=%0b lost=%0b cnt=%0d, need all 0",
                     locked, err_pulse, sync_lost, err_count);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic check_lock_rise(input string name);
        for (int i = 1; i <= 11; i++) begin
            send(1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (locked !== (i == 11)) begin
                n_fail++;
                $display("FAIL %s bit %0d: locked=%0b need %0b", name, i, locked, (i == 11));
            end
        end
    endtask

    task automatic test_lock();
        check_lock_rise("lock_rise");
        for (int i = 0; i < 100; i++) begin
            send(1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (locked !== 1'b1 || err_pulse !== 1'b0 || err_count !== 16'd0) begin
                n_fail++;
                $display("FAIL clean_run bit %0d: locked=%0b pulse=%0b cnt=%0d need 1/0/0",
                         i, locked, err_pulse, err_count);
            end
        end
    endtask

    task automatic test_single_err();
        send(1'b1, 1'b1, 1'b0);
        exp_cnt++;
        n_cmp++;
        if (err_pulse !== 1'b1 || err_count !== exp_cnt || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL single_err: pulse=%0b cnt=%0d locked=%0b need 1/%0d/1",
                     err_pulse, err_count, locked, exp_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (err_pulse !== 1'b0 || err_count !== exp_cnt || locked !== 1'b1) begin
                n_fail++;
                $display("FAIL single_err_after %0d: pulse=%0b cnt=%0d locked=%0b need 0/%0d/1",
                         i, err_pulse, err_count, locked, exp_cnt);
            end
        end
    endtask

    task automatic test_loss();
        send(1'b0, 1'b0, 1'b1);
        exp_cnt = '0;
        n_cmp++;
        if (err_count !== 16'd0) begin
            n_fail++;
            $display("FAIL clr_idle: cnt=%0d need 0", err_count);
        end
        for (int k = 1; k <= 4; k++) begin
            send(1'b1, 1'b1, 1'b0);
            exp_cnt++;
            n_cmp++;
            if (err_count !== exp_cnt || err_pulse !== 1'b1 ||
                sync_lost !== (k == 4) || locked !== (k != 4)) begin
                n_fail++;
                $display("FAIL loss_err %0d: cnt=%0d pulse=%0b lost=%0b locked=%0b need %0d/1/%0b/%0b",
                         k, err_count, err_pulse, sync_lost, locked, exp_cnt, (k == 4), (k != 4));
            end
        end
        send(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (sync_lost !== 1'b0 || err_pulse !== 1'b0 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL loss_pulse_drop: lost=%0b pulse=%0b locked=%0b need 0/0/0",
                     sync_lost, err_pulse, locked);
        end
        check_lock_rise("relock");
        n_cmp++;
        if (err_count !== 16'd4) begin
            n_fail++;
            $display("FAIL cnt_kept: cnt=%0d need 4", err_count);
        end
    endtask

    task automatic test_all_ones();
        do_reset();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_bit = 1'b1; clr_count = 1'b0;
            @(posedge clk);
            #1;
            n_cmp++;
            if (locked !== 1'b0 || err_count !== 16'd0) begin
                n_fail++;
                $display("FAIL all_ones bit %0d: locked=%0b cnt=%0d need 0/0", i, locked, err_count);
            end
        end
    endtask

    task automatic test_gaps();
        int nv;
        do_reset();
        nv = 0;
        for (int c = 0; c < 36; c++) begin
            send((c % 3) == 0, 1'b0, 1'b0);
            if ((c % 3) == 0) nv++;
            n_cmp++;
            if (locked !== (nv >= 11)) begin
                n_fail++;
                $display("FAIL gap_lock cycle %0d (valid %0d): locked=%0b need %0b",
                         c, nv, locked, (nv >= 11));
            end
        end
        send(1'b1, 1'b1, 1'b1);
        n_cmp++;
        if (err_pulse !== 1'b1 || err_count !== 16'd0 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_priority: pulse=%0b cnt=%0d locked=%0b need 1/0/1",
                     err_pulse, err_count, locked);
        end
    endtask

    task automatic test_reset_locked();
        for (int i = 0; i < 5; i++) send(1'b1, (i % 2) == 0, 1'b0);
        n_cmp++;
        if (err_count !== 16'd3 || locked !== 1'b1 || err_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: cnt=%0d locked=%0b pulse=%0b need 3/1/1",
                     err_count, locked, err_pulse);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({locked, err_pulse, sync_lost} !== 3'b000 || err_count !== 16'd0) begin
            n_fail++;
            $display("FAIL async_reset: locked=%0b pulse=%0b lost=%0b cnt=%0d need all 0",
                     locked, err_pulse, sync_lost, err_count);
        end
        // Valid bits are offered during reset, and none may be consumed.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_bit = 1'($urandom);
        end
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        check_lock_rise("reset_relock");
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; idx = 0;
        pat = 7'b0001011;
        exp_cnt = '0;
        test_reset();
        test_lock();
        test_single_err();
        test_loss();
        test_all_ones();
        test_gaps();
        test_reset_locked();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
